// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit in the EX stage.
// It runs a 32-step shift-add multiply or restoring divide, holds the pipeline
// with stall, then presents the result for one cycle with done.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3_ex,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        kill,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [2:0]  op_r;
    logic        neg_res_r;   // product/quotient must be negated at the end
    logic        neg_rem_r;   // remainder takes the dividend's sign
    logic [31:0] opnd_r;      // multiplicand (mul) or divisor (div), magnitude
    logic [63:0] acc_r;       // mul: {high, low/multiplier}; div: low word is quotient
    logic [32:0] rem_r;       // partial remainder for division

    // Two's-complement negation helpers.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    logic        sgn_a_s, sgn_b_s;
    logic        neg_a_s, neg_b_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic        div_zero_s, div_ovf_s, fast_s;
    logic [31:0] fast_res_s;

    // Decode signedness of each operand, form magnitudes and detect the fast path.
    always_comb begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
        case (funct3_ex)
            3'd0, 3'd1, 3'd4, 3'd6: begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
            3'd2:                   begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
            3'd3, 3'd5, 3'd7:       begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
            default:                begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
        endcase
        neg_a_s    = sgn_a_s & src_a[31];
        neg_b_s    = sgn_b_s & src_b[31];
        mag_a_s    = neg_a_s ? neg32(src_a) : src_a;
        mag_b_s    = neg_b_s ? neg32(src_b) : src_b;
        div_zero_s = (src_b == 32'd0);
        div_ovf_s  = ((funct3_ex == 3'd4) || (funct3_ex == 3'd6)) &&
                     (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
        fast_s     = funct3_ex[2] & (div_zero_s | div_ovf_s);
        if (div_zero_s) begin
            fast_res_s = funct3_ex[1] ? src_a : 32'hFFFF_FFFF;
        end else if (div_ovf_s) begin
            fast_res_s = funct3_ex[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            fast_res_s = 32'd0;
        end
    end

    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_shift_s;
    logic [33:0] div_diff_s;
    logic        div_ge_s;
    logic [32:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic [63:0] prod_s;
    logic [31:0] quo_s, rem_s, final_s;

    // One iteration of shift-add multiply and restoring divide, plus final sign fix-up.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_next_s  = {mul_sum_s, acc_r[31:1]};
        div_shift_s = {rem_r[31:0], acc_r[31]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
        div_ge_s    = ~div_diff_s[33];
        rem_next_s  = div_ge_s ? div_diff_s[32:0] : div_shift_s;
        quo_next_s  = {acc_r[30:0], div_ge_s};
        prod_s      = neg_res_r ? neg64(mul_next_s) : mul_next_s;
        quo_s       = neg_res_r ? neg32(quo_next_s) : quo_next_s;
        rem_s       = neg_rem_r ? neg32(rem_next_s[31:0]) : rem_next_s[31:0];
        case (op_r)
            3'd0:             final_s = prod_s[31:0];
            3'd1, 3'd2, 3'd3: final_s = prod_s[63:32];
            3'd4, 3'd5:       final_s = quo_s;
            3'd6, 3'd7:       final_s = rem_s;
            default:          final_s = 32'd0;
        endcase
    end

    // Pipeline hold: pending start in IDLE or any BUSY cycle; never during reset.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            stall = 1'b0;
        end else if (state_r == BUSY) begin
            stall = 1'b1;
        end else if ((state_r == IDLE) && start && !kill) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Sequencer FSM with datapath registers and registered done/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 6'd0;
            op_r      <= 3'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            opnd_r    <= 32'd0;
            acc_r     <= 64'd0;
            rem_r     <= 33'd0;
            done      <= 1'b0;
            result    <= 32'd0;
        end else if (kill) begin
            state_r <= IDLE;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r      <= funct3_ex;
                        neg_res_r <= neg_a_s ^ neg_b_s;
                        neg_rem_r <= neg_a_s;
                        cnt_r     <= 6'd0;
                        rem_r     <= 33'd0;
                        if (funct3_ex[2]) begin
                            opnd_r <= mag_b_s;
                            acc_r  <= {32'd0, mag_a_s};
                        end else begin
                            opnd_r <= mag_a_s;
                            acc_r  <= {32'd0, mag_b_s};
                        end
                        if (fast_s) begin
                            result  <= fast_res_s;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            state_r <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    done  <= 1'b0;
                    cnt_r <= cnt_r + 6'd1;
                    if (op_r[2]) begin
                        acc_r <= {32'd0, quo_next_s};
                        rem_r <= rem_next_s;
                    end else begin
                        acc_r <= mul_next_s;
                    end
                    if (cnt_r == 6'd31) begin
                        result  <= final_s;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: results, latency, stall length,
// kill/reset aborts and back-to-back operation.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3_ex;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int pass_n  = 0;
    int total_n = 0;

    // 10 ns clock.
    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3_ex (funct3_ex),
        .src_a     (src_a),
        .src_b     (src_b),
        .kill      (kill),
        .stall     (stall),
        .done      (done),
        .result    (result)
    );

    // Issue one op at a negedge and watch up to 60 cycles; k counts cycles from the issue cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stall_n,
                          output int done_n);
        res = 32'd0; lat = -1; stall_n = 0; done_n = 0;
        @(negedge clk);
        start = 1'b1; funct3_ex = f; src_a = a; src_b = b; kill = 1'b0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (stall) stall_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin lat = k; res = result; end
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; kill = 1'b0; funct3_ex = 3'd0; src_a = 32'd1; src_b = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total_n++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else pass_n++;
        total_n++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_n++;
        total_n++; if (result !== 32'd0) $display("FAIL reset_result: got %h expected 00000000", result); else pass_n++;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  f  [4];
        logic [31:0] a  [4];
        logic [31:0] b  [4];
        logic [31:0] ex [4];
        logic [31:0] res;
        int lat, sn, dn;
        f  = '{3'd0, 3'd1, 3'd2, 3'd3};
        a  = '{32'h0000_0007, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        b  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ex = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], res, lat, sn, dn);
            total_n++; if (res !== ex[i]) $display("FAIL mul%0d_result: got %h expected %h", i, res, ex[i]); else pass_n++;
            total_n++; if (lat != 33) $display("FAIL mul%0d_latency: got %0d expected 33", i, lat); else pass_n++;
            total_n++; if (sn != 33) $display("FAIL mul%0d_stall_cycles: got %0d expected 33", i, sn); else pass_n++;
            total_n++; if (dn != 1) $display("FAIL mul%0d_done_pulses: got %0d expected 1", i, dn); else pass_n++;
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  f  [4];
        logic [31:0] a  [4];
        logic [31:0] b  [4];
        logic [31:0] ex [4];
        logic [31:0] res;
        int lat, sn, dn;
        f  = '{3'd4, 3'd6, 3'd4, 3'd6};
        a  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        b  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ex = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], res, lat, sn, dn);
            total_n++; if (res !== ex[i]) $display("FAIL fast%0d_result: got %h expected %h", i, res, ex[i]); else pass_n++;
            total_n++; if (lat != 1) $display("FAIL fast%0d_latency: got %0d expected 1", i, lat); else pass_n++;
            total_n++; if (sn != 1) $display("FAIL fast%0d_stall_cycles: got %0d expected 1", i, sn); else pass_n++;
            total_n++; if (dn != 1) $display("FAIL fast%0d_done_pulses: got %0d expected 1", i, dn); else pass_n++;
        end
    endtask

    task automatic test_div();
        logic [2:0]  f  [4];
        logic [31:0] a  [4];
        logic [31:0] b  [4];
        logic [31:0] ex [4];
        logic [31:0] res;
        int lat, sn, dn;
        f  = '{3'd4, 3'd6, 3'd5, 3'd7};
        a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        b  = '{32'd2, 32'd2, 32'd7, 32'd7};
        ex = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], res, lat, sn, dn);
            total_n++; if (res !== ex[i]) $display("FAIL div%0d_result: got %h expected %h", i, res, ex[i]); else pass_n++;
            total_n++; if (lat != 33) $display("FAIL div%0d_latency: got %0d expected 33", i, lat); else pass_n++;
            total_n++; if (sn != 33) $display("FAIL div%0d_stall_cycles: got %0d expected 33", i, sn); else pass_n++;
            total_n++; if (dn != 1) $display("FAIL div%0d_done_pulses: got %0d expected 1", i, dn); else pass_n++;
        end
    endtask

    // Abort a DIVU at BUSY count 10 with kill (use_rst=0) or rst (use_rst=1).
    task automatic test_abort(input logic use_rst, input logic [31:0] exp_res);
        int done_seen;
        logic st11;
        done_seen = 0; st11 = 1'b0;
        @(negedge clk);
        start = 1'b1; funct3_ex = 3'd5; src_a = 32'd100; src_b = 32'd7; kill = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (done) done_seen++;
            if (k == 11) begin
                st11 = stall;
                start = 1'b0;
                if (use_rst) rst = 1'b1; else kill = 1'b1;
            end
            @(negedge clk);
        end
        kill = 1'b0; rst = 1'b0;
        #1;
        total_n++; if (st11 !== 1'b1) $display("FAIL abort%0d_busy_stall: got %b expected 1", use_rst, st11); else pass_n++;
        total_n++; if (stall !== 1'b0) $display("FAIL abort%0d_stall_after: got %b expected 0", use_rst, stall); else pass_n++;
        total_n++; if (result !== exp_res) $display("FAIL abort%0d_result: got %h expected %h", use_rst, result, exp_res); else pass_n++;
        for (int k = 0; k < 40; k++) begin
            if (done) done_seen++;
            @(negedge clk); #1;
        end
        total_n++; if (done_seen != 0) $display("FAIL abort%0d_done_seen: got %0d expected 0", use_rst, done_seen); else pass_n++;
        total_n++; if (result !== exp_res) $display("FAIL abort%0d_result_hold: got %h expected %h", use_rst, result, exp_res); else pass_n++;
    endtask

    task automatic test_back_to_back();
        int dn, lat1, lat2;
        logic [31:0] r1, r2;
        logic st_done;
        dn = 0; lat1 = -1; lat2 = -1; r1 = 32'd0; r2 = 32'd0; st_done = 1'b1;
        @(negedge clk);
        start = 1'b1; funct3_ex = 3'd0; src_a = 32'd3; src_b = 32'd4; kill = 1'b0;
        for (int k = 0; k < 90; k++) begin
            #1;
            if (done) begin
                dn++;
                if (dn == 1) begin
                    r1 = result; lat1 = k; st_done = stall;
                    src_a = 32'd5; src_b = 32'd6;
                end else if (dn == 2) begin
                    r2 = result; lat2 = k; start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        total_n++; if (dn != 2) $display("FAIL b2b_done_pulses: got %0d expected 2", dn); else pass_n++;
        total_n++; if (r1 !== 32'd12) $display("FAIL b2b_first_result: got %h expected 0000000c", r1); else pass_n++;
        total_n++; if (r2 !== 32'd30) $display("FAIL b2b_second_result: got %h expected 0000001e", r2); else pass_n++;
        total_n++; if (lat1 != 33) $display("FAIL b2b_first_latency: got %0d expected 33", lat1); else pass_n++;
        total_n++; if (lat2 != 67) $display("FAIL b2b_second_latency: got %0d expected 67", lat2); else pass_n++;
        total_n++; if (st_done !== 1'b0) $display("FAIL b2b_done_stall: got %b expected 0", st_done); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_fast_path();
        test_div();
        test_abort(1'b0, 32'd2);
        test_abort(1'b1, 32'd0);
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
